regfile_sb: RTL

//  Parametrised multi-port integer register file with a per-register busy scoreboard.

---
 rtl/regfile_sb.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Multi-port integer register file with a per-register busy scoreboard.
//   Decode reads operands together with their busy flags and marks a
//   destination busy at issue. Writeback ports store results and clear busy.
//   Register 0 is hardwired to zero and is never busy.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset, clears registers and busy bits
//   ra         NREAD packed read addresses, port i at [i*AW +: AW]
//   rd         NREAD packed read data, port i at [i*XLEN +: XLEN]
//   rbusy      busy flag of the addressed register, one per read port
//   we         write enable per write port (higher index has higher priority)
//   wa         NWRITE packed write addresses
//   wd         NWRITE packed write data
//   iss_valid  issue strobe: mark iss_rd busy at the next edge
//   iss_rd     destination register being issued
//   busy_vec   full scoreboard, bit 0 always 0
//
// Configuration
//   REGFILE_BYPASS_EN  when defined, a write in flight is forwarded to any
//                      read port addressing the same register in the same
//                      cycle. When undefined, reads show pre-edge state.
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     ra,
  output logic [NREAD*XLEN-1:0]   rd,
  output logic [NREAD-1:0]        rbusy,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    wa,
  input  logic [NWRITE*XLEN-1:0]  wd,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  output logic [NREGS-1:0]        busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // Register storage. Ports are visited in ascending order so the last
  // non-blocking assignment, i.e. the highest enabled port, wins on a
  // same-address conflict. Address 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (we[p] && (wa[p*AW +: AW] != '0))
          regs[wa[p*AW +: AW]] <= wd[p*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard next state. Clears are applied first and the issue set last,
  // so a new producer supersedes a writeback from the old one in the same
  // cycle. Bit 0 is forced low so x0 can never look busy.
  always_comb begin
    busy_next = busy;
    for (int p = 0; p < NWRITE; p++) begin
      if (we[p]) busy_next[wa[p*AW +: AW]] = 1'b0;
    end
    if (iss_valid) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign busy_vec = busy;

  // Combinational read ports. Outputs are gated by rst so that any bypass
  // path cannot leak write data while the block is held in reset.
  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = ra[i*AW +: AW];

    always_comb begin
      data = regs[addr];
      bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
      // Forward the winning in-flight write; the register only stays busy
      // if it is being re-issued in this very cycle.
      for (int p = 0; p < NWRITE; p++) begin
        if (we[p] && (wa[p*AW +: AW] == addr)) begin
          data = wd[p*XLEN +: XLEN];
          bsy  = iss_valid && (iss_rd == addr);
        end
      end
`endif
      if (rst || (addr == '0)) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign rd[i*XLEN +: XLEN] = data;
    assign rbusy[i]           = bsy;
  end

endmodule
